// File: rtl/eth_axis_rx.sv
// Ethernet frame receiver: splits a byte stream into dest/src/EtherType header
// fields and a registered payload stream with independent handshakes.
module eth_axis_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  m_eth_hdr_valid,
   input  logic                  m_eth_hdr_ready,
   output logic [47:0]           m_eth_dest_mac,
   output logic [47:0]           m_eth_src_mac,
   output logic [15:0]           m_eth_type,
   output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
   output logic                  m_eth_payload_axis_tvalid,
   input  logic                  m_eth_payload_axis_tready,
   output logic                  m_eth_payload_axis_tlast,
   output logic                  m_eth_payload_axis_tuser,
   output logic                  busy,
   output logic                  error_header_early_termination
);

   generate
      if (DATA_WIDTH != 8) begin : g_width_check
         $error("eth_axis_rx supports only DATA_WIDTH = 8");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [111:0]            hdr_q, hdr_d;
   logic                    hdr_valid_q, hdr_valid_d;
   logic [DATA_WIDTH-1:0]   pay_data_q, pay_data_d;
   logic                    pay_valid_q, pay_valid_d;
   logic                    pay_last_q, pay_last_d;
   logic                    pay_user_q, pay_user_d;
   logic                    busy_q, busy_d;
   logic                    err_q, err_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      hdr_d         = hdr_q;
      hdr_valid_d   = hdr_valid_q;
      pay_data_d    = pay_data_q;
      pay_valid_d   = pay_valid_q;
      pay_last_d    = pay_last_q;
      pay_user_d    = pay_user_q;
      busy_d        = busy_q;
      err_d         = 1'b0;
      s_axis_tready = 1'b0;

      // Output-side handshakes are evaluated first so new input can override them.
      if (hdr_valid_q && m_eth_hdr_ready) begin
         hdr_valid_d = 1'b0;
         hdr_d       = '0;
      end
      if (pay_valid_q && m_eth_payload_axis_tready) begin
         pay_valid_d = 1'b0;
         if (pay_last_q) begin
            busy_d = 1'b0;
         end
      end

      case (state_q)
         IDLE, HDR: begin
            s_axis_tready = !hdr_valid_q;
            if (s_axis_tvalid && s_axis_tready) begin
               hdr_d  = {hdr_q[103:0], s_axis_tdata};
               busy_d = 1'b1;
               if (s_axis_tlast) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  hdr_d   = '0;
               end else if (cnt_q == 4'd13) begin
                  hdr_valid_d = 1'b1;
                  state_d     = PAYLOAD;
                  cnt_d       = '0;
               end else begin
                  cnt_d   = cnt_q + 4'd1;
                  state_d = HDR;
               end
            end
         end
         PAYLOAD: begin
            s_axis_tready = !pay_valid_q || m_eth_payload_axis_tready;
            if (s_axis_tvalid && s_axis_tready) begin
               pay_valid_d = 1'b1;
               pay_data_d  = s_axis_tdata;
               pay_last_d  = s_axis_tlast;
               pay_user_d  = s_axis_tuser && s_axis_tlast;
               if (s_axis_tlast) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hdr_q       <= '0;
         hdr_valid_q <= 1'b0;
         pay_data_q  <= '0;
         pay_valid_q <= 1'b0;
         pay_last_q  <= 1'b0;
         pay_user_q  <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hdr_q       <= hdr_d;
         hdr_valid_q <= hdr_valid_d;
         pay_data_q  <= pay_data_d;
         pay_valid_q <= pay_valid_d;
         pay_last_q  <= pay_last_d;
         pay_user_q  <= pay_user_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign m_eth_hdr_valid                = hdr_valid_q;
   assign m_eth_dest_mac                 = hdr_q[111:64];
   assign m_eth_src_mac                  = hdr_q[63:16];
   assign m_eth_type                     = hdr_q[15:0];
   assign m_eth_payload_axis_tdata       = pay_data_q;
   assign m_eth_payload_axis_tvalid      = pay_valid_q;
   assign m_eth_payload_axis_tlast       = pay_last_q;
   assign m_eth_payload_axis_tuser       = pay_user_q;
   assign busy                           = busy_q;
   assign error_header_early_termination = err_q;

endmodule

// File: tb/tb_eth_axis_rx.sv
// Self-checking bench for eth_axis_rx: a per-cycle vector table followed by
// directed multi-frame sequences (ARP frame, header backpressure, errors, reset).
module tb_eth_axis_rx;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   s_tdata;
   logic         s_tvalid, s_tlast, s_tuser, s_tready;
   logic         hdr_valid, hdr_ready;
   logic [47:0]  dest_mac, src_mac;
   logic [15:0]  eth_type;
   logic [7:0]   p_data;
   logic         p_valid, p_ready, p_last, p_user;
   logic         busy, err;

   int compared = 0;
   int mismatched = 0;
   int errCount = 0;
   bit bpMode = 0;
   logic [9:0]   payQ [$];
   logic [111:0] hdrQ [$];

   localparam logic [111:0] ARP_HDR = 112'hffffffffffff_5a5152535455_0806;
   localparam logic [111:0] TAB_HDR = 112'h112233445566_a1a2a3a4a5a6_0800;
   logic [7:0] arpPay [28] = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                               8'h5a, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55,
                               8'hc0, 8'ha8, 8'h01, 8'h64,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'hc0, 8'ha8, 8'h01, 8'h65};

   typedef struct {
      logic [7:0]   d;
      logic         v, l, u, hr, pr;
      logic         eTready, eHv;
      logic [111:0] eHdr;
      logic         ePv;
      logic [7:0]   ePd;
      logic         ePl, ePu, eBusy, eErr;
   } vec_t;
   vec_t vecs [$];

   eth_axis_rx #(.DATA_WIDTH(8)) dut (
      .clk                            (clk),
      .rst_n                          (rst_n),
      .s_axis_tdata                   (s_tdata),
      .s_axis_tvalid                  (s_tvalid),
      .s_axis_tready                  (s_tready),
      .s_axis_tlast                   (s_tlast),
      .s_axis_tuser                   (s_tuser),
      .m_eth_hdr_valid                (hdr_valid),
      .m_eth_hdr_ready                (hdr_ready),
      .m_eth_dest_mac                 (dest_mac),
      .m_eth_src_mac                  (src_mac),
      .m_eth_type                     (eth_type),
      .m_eth_payload_axis_tdata       (p_data),
      .m_eth_payload_axis_tvalid      (p_valid),
      .m_eth_payload_axis_tready      (p_ready),
      .m_eth_payload_axis_tlast       (p_last),
      .m_eth_payload_axis_tuser       (p_user),
      .busy                           (busy),
      .error_header_early_termination (err)
   );

   always #5 clk = ~clk;

   // Record completed transfers and error-pulse cycles half a cycle before the edge that commits them.
   always @(negedge clk) begin
      if (rst_n) begin
         if (p_valid && p_ready) payQ.push_back({p_last, p_user, p_data});
         if (hdr_valid && hdr_ready) hdrQ.push_back({dest_mac, src_mac, eth_type});
         if (err) errCount++;
      end
   end

   // Random payload backpressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bpMode) p_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic checkOutput(input string name, input logic [111:0] act, input logic [111:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void addRow(input logic [7:0] d, input logic v, l, u, hr, pr,
                                  input logic eTready, eHv, input logic [111:0] eHdr,
                                  input logic ePv, input logic [7:0] ePd,
                                  input logic ePl, ePu, eBusy, eErr);
      vec_t r;
      r.d = d; r.v = v; r.l = l; r.u = u; r.hr = hr; r.pr = pr;
      r.eTready = eTready; r.eHv = eHv; r.eHdr = eHdr; r.ePv = ePv; r.ePd = ePd;
      r.ePl = ePl; r.ePu = ePu; r.eBusy = eBusy; r.eErr = eErr;
      vecs.push_back(r);
   endfunction

   function automatic void buildFrame(output logic [7:0] q [$], input logic [111:0] hdr,
                                      input int nHdr, input int nPay);
      q = {};
      for (int i = 0; i < nHdr; i++) q.push_back(hdr[111 - 8*i -: 8]);
      for (int i = 0; i < nPay; i++) q.push_back(arpPay[i]);
   endfunction

   // Drive bytes one by one, holding each until the DUT accepts it (bounded).
   task automatic applyStimulus(input logic [7:0] bytes [$], input bit lastFlag, input bit userLast);
      bit acc;
      int tries;
      for (int i = 0; i < bytes.size(); i++) begin
         s_tdata  = bytes[i];
         s_tvalid = 1'b1;
         s_tlast  = lastFlag && (i == bytes.size() - 1);
         s_tuser  = userLast && s_tlast;
         tries    = 0;
         acc      = 0;
         while (!acc && tries < 300) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            tries++;
         end
         if (!acc) begin
            checkOutput("send_timeout", 112'(i), 112'(bytes.size()));
            break;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic waitPay(input int n, input string name);
      int t = 0;
      while (payQ.size() < n && t < 600) begin
         @(posedge clk);
         #1;
         t++;
      end
      checkOutput(name, 112'(payQ.size()), 112'(n));
   endtask

   task automatic checkPayload(input int base, input bit userLast, input string name);
      for (int i = 0; i < 28; i++) begin
         if (base + i < payQ.size())
            checkOutput($sformatf("%s_byte%0d", name, i), 112'(payQ[base + i]),
                        112'({i == 27, userLast && (i == 27), arpPay[i]}));
      end
   endtask

   initial begin
      logic [7:0]   frame [$];
      logic [111:0] heldHdr;
      bit           stallOk;

      rst_n = 1'b0; s_tdata = '0; s_tvalid = 0; s_tlast = 0; s_tuser = 0;
      hdr_ready = 0; p_ready = 1;
      #12;
      checkOutput("reset_outputs", 112'({hdr_valid, p_valid, p_data, p_last, p_user, busy, err}), 112'(0));
      checkOutput("reset_fields", {dest_mac, src_mac, eth_type}, 112'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Per-cycle table: header held unacknowledged, payload with a tuser on a non-last byte,
      // then a stalled next-frame byte that is a single-byte (early-terminated) frame.
      for (int i = 0; i < 13; i++)
         addRow(TAB_HDR[111 - 8*i -: 8], 1, 0, 0, 0, 1, 1, 0, '0, 0, '0, 0, 0, 1, 0);
      addRow(8'h00, 1, 0, 0, 0, 1, 1, 1, TAB_HDR, 0, '0, 0, 0, 1, 0);
      addRow(8'hde, 1, 0, 0, 0, 1, 1, 1, TAB_HDR, 1, 8'hde, 0, 0, 1, 0);
      addRow(8'had, 1, 0, 1, 0, 1, 1, 1, TAB_HDR, 1, 8'had, 0, 0, 1, 0);
      addRow(8'hbe, 1, 1, 1, 0, 1, 1, 1, TAB_HDR, 1, 8'hbe, 1, 1, 1, 0);
      addRow(8'h77, 1, 1, 0, 1, 1, 0, 0, '0, 0, '0, 0, 0, 0, 0);
      addRow(8'h77, 1, 1, 0, 1, 1, 1, 0, '0, 0, '0, 0, 0, 0, 1);
      addRow(8'h00, 0, 0, 0, 1, 1, 1, 0, '0, 0, '0, 0, 0, 0, 0);

      for (int r = 0; r < vecs.size(); r++) begin
         s_tdata = vecs[r].d; s_tvalid = vecs[r].v; s_tlast = vecs[r].l; s_tuser = vecs[r].u;
         hdr_ready = vecs[r].hr; p_ready = vecs[r].pr;
         @(negedge clk);
         checkOutput($sformatf("row%0d_tready", r), 112'(s_tready), 112'(vecs[r].eTready));
         @(posedge clk);
         #1;
         checkOutput($sformatf("row%0d_ctrl", r), 112'({hdr_valid, p_valid, busy, err}),
                     112'({vecs[r].eHv, vecs[r].ePv, vecs[r].eBusy, vecs[r].eErr}));
         if (vecs[r].eHv)
            checkOutput($sformatf("row%0d_hdr", r), {dest_mac, src_mac, eth_type}, vecs[r].eHdr);
         if (vecs[r].ePv)
            checkOutput($sformatf("row%0d_pay", r), 112'({p_data, p_last, p_user}),
                        112'({vecs[r].ePd, vecs[r].ePl, vecs[r].ePu}));
      end
      s_tvalid = 0; s_tlast = 0; s_tuser = 0;

      // ARP frame, both readies high.
      payQ = {}; hdrQ = {}; errCount = 0; hdr_ready = 1; p_ready = 1;
      buildFrame(frame, ARP_HDR, 14, 28);
      applyStimulus(frame, 1, 0);
      waitPay(28, "arp_pay_count");
      checkPayload(0, 0, "arp");
      checkOutput("arp_hdr_count", 112'(hdrQ.size()), 112'(1));
      if (hdrQ.size() > 0) checkOutput("arp_hdr_fields", hdrQ[0], ARP_HDR);
      checkOutput("arp_busy_low", 112'(busy), 112'(0));

      // Header held for 20 cycles: payload flows, next frame stalls, fields stable.
      payQ = {}; hdrQ = {}; hdr_ready = 0;
      applyStimulus(frame, 1, 0);
      s_tdata = 8'hff; s_tvalid = 1;
      stallOk = 1;
      heldHdr = {dest_mac, src_mac, eth_type};
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_tready || !hdr_valid || {dest_mac, src_mac, eth_type} != ARP_HDR) stallOk = 0;
      end
      checkOutput("hold_fields", heldHdr, ARP_HDR);
      checkOutput("hold_stall", 112'(stallOk), 112'(1));
      checkOutput("hold_pay_flowed", 112'(payQ.size()), 112'(28));
      @(posedge clk);
      #1;
      hdr_ready = 1;
      applyStimulus(frame, 1, 0);
      waitPay(56, "hold_pay_count");
      checkPayload(28, 0, "hold2");
      checkOutput("hold_hdr_count", 112'(hdrQ.size()), 112'(2));
      if (hdrQ.size() > 1) checkOutput("hold_hdr2", hdrQ[1], ARP_HDR);

      // Random payload backpressure.
      payQ = {}; hdrQ = {}; bpMode = 1;
      applyStimulus(frame, 1, 0);
      waitPay(28, "bp_pay_count");
      bpMode = 0;
      @(posedge clk);
      #2;
      p_ready = 1;
      checkPayload(0, 0, "bp");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_no_extra", 112'(payQ.size()), 112'(28));

      // Early termination at byte 10 and at byte 14, then a good frame.
      payQ = {}; hdrQ = {}; errCount = 0;
      buildFrame(frame, ARP_HDR, 10, 0);
      applyStimulus(frame, 1, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("early10_err", 112'(errCount), 112'(1));
      buildFrame(frame, ARP_HDR, 14, 0);
      applyStimulus(frame, 1, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("early14_err", 112'(errCount), 112'(2));
      checkOutput("early_no_hdr", 112'({hdrQ.size(), busy}), 112'(0));
      buildFrame(frame, ARP_HDR, 14, 28);
      applyStimulus(frame, 1, 0);
      waitPay(28, "early_good_count");
      checkPayload(0, 0, "early_good");
      checkOutput("early_good_hdr_count", 112'(hdrQ.size()), 112'(1));
      if (hdrQ.size() > 0) checkOutput("early_good_hdr", hdrQ[0], ARP_HDR);

      // Bad-frame flag on tlast.
      payQ = {}; hdrQ = {};
      applyStimulus(frame, 1, 1);
      waitPay(28, "tuser_count");
      checkPayload(0, 1, "tuser");

      // Reset asserted with payload byte 5 just accepted.
      payQ = {}; hdrQ = {};
      buildFrame(frame, ARP_HDR, 14, 5);
      applyStimulus(frame, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_outputs", 112'({hdr_valid, p_valid, p_data, p_last, p_user, busy, err}), 112'(0));
      checkOutput("midreset_fields", {dest_mac, src_mac, eth_type}, 112'(0));
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      payQ = {}; hdrQ = {};
      buildFrame(frame, ARP_HDR, 14, 28);
      applyStimulus(frame, 1, 0);
      waitPay(28, "postreset_count");
      checkPayload(0, 0, "postreset");
      checkOutput("postreset_hdr_count", 112'(hdrQ.size()), 112'(1));
      if (hdrQ.size() > 0) checkOutput("postreset_hdr", hdrQ[0], ARP_HDR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
